rom_burst_reader: RTL and testbench

- Sequencer in front of the single-port, 1-cycle-latency configuration/pattern ROM (registered output, holds when not read).
- On a start command it reads a contiguous address range and presents the words as a valid/ready stream with backpressure.
- Consumers include the ILAS config octet builder and the test-pattern generator.
- Owns the ROM read port exclusively and guarantees no word is lost while the sink stalls.

---
 rtl/rom_burst_reader_pkg.sv | 15 +
 rtl/rom_burst_reader_if.sv | 41 ++++
 rtl/rbr_skid_fifo.sv | 55 +++++
 rtl/rom_burst_reader.sv | 128 ++++++++++++
 tb/tb_rom_burst_reader.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_burst_reader_pkg.sv
// Shared types and constants for the ROM burst reader and its skid FIFO.
package rom_burst_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_DONE
   } rbr_state_e;

   localparam int RBR_FIFO_DEPTH = 2;
   localparam int RBR_CNT_W      = $clog2(RBR_FIFO_DEPTH + 1);
   localparam int RBR_PTR_W      = $clog2(RBR_FIFO_DEPTH);

endpackage

// File: rtl/rom_burst_reader_if.sv
// Command, ROM read port and stream signals of the ROM burst reader.
// i_abort exists only when ROM_BURST_READER_ABORT_EN is defined.
interface rom_burst_reader_if #(
   parameter int READ_ADDR_WIDTH = 8,
   parameter int WIDTH           = 8,
   parameter int LEN_WIDTH       = 9
);
   logic                       i_start;
   logic [READ_ADDR_WIDTH-1:0] i_base_addr;
   logic [LEN_WIDTH-1:0]       i_len;
   logic                       o_busy;
   logic                       o_done;
   logic [READ_ADDR_WIDTH-1:0] o_rom_addr;
   logic                       o_rom_rd_en;
   logic [WIDTH-1:0]           i_rom_data;
   logic [WIDTH-1:0]           o_data;
   logic                       o_valid;
   logic                       o_last;
   logic                       i_ready;
`ifdef ROM_BURST_READER_ABORT_EN
   logic                       i_abort;

   modport master (
      output i_start, i_base_addr, i_len, i_rom_data, i_ready, i_abort,
      input  o_busy, o_done, o_rom_addr, o_rom_rd_en, o_data, o_valid, o_last
   );
   modport slave (
      input  i_start, i_base_addr, i_len, i_rom_data, i_ready, i_abort,
      output o_busy, o_done, o_rom_addr, o_rom_rd_en, o_data, o_valid, o_last
   );
`else
   modport master (
      output i_start, i_base_addr, i_len, i_rom_data, i_ready,
      input  o_busy, o_done, o_rom_addr, o_rom_rd_en, o_data, o_valid, o_last
   );
   modport slave (
      input  i_start, i_base_addr, i_len, i_rom_data, i_ready,
      output o_busy, o_done, o_rom_addr, o_rom_rd_en, o_data, o_valid, o_last
   );
`endif
endinterface

// File: rtl/rbr_skid_fifo.sv
// Two-entry FIFO holding {last, data} words returned by the ROM.
// Occupancy is bounded by the reader's issue rule; overflow is a checked error.
module rbr_skid_fifo
   import rom_burst_reader_pkg::*;
#(
   parameter int DATA_W = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push_i,
   input  logic [DATA_W-1:0]    push_data_i,
   input  logic                 pop_i,
   input  logic                 flush_i,
   output logic [DATA_W-1:0]    head_o,
   output logic                 valid_o,
   output logic [RBR_CNT_W-1:0] count_o
);

   logic [DATA_W-1:0]    mem_q [RBR_FIFO_DEPTH];
   logic [RBR_PTR_W-1:0] wr_ptr_q;
   logic [RBR_PTR_W-1:0] rd_ptr_q;
   logic [RBR_CNT_W-1:0] count_q;

   // NOTE: the storage is reset so the stream outputs read 0 out of reset; with
   // only two entries this costs little, deeper memories would normally skip it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + RBR_PTR_W'(1);
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + RBR_PTR_W'(1);
         end
         count_q <= count_q + RBR_CNT_W'(push_i) - RBR_CNT_W'(pop_i);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

   overflow_a: assert property (@(posedge clk) disable iff (rst)
      !(push_i && !pop_i && !flush_i && (count_q == RBR_CNT_W'(RBR_FIFO_DEPTH))));

endmodule

// File: rtl/rom_burst_reader.sv
// Reads a contiguous ROM range and streams it out with valid/ready backpressure.
// Optional abort input enabled by defining ROM_BURST_READER_ABORT_EN.
module rom_burst_reader
   import rom_burst_reader_pkg::*;
#(
   parameter int READ_ADDR_WIDTH = 8,
   parameter int WIDTH           = 8,
   parameter int LEN_WIDTH       = 9
) (
   input  logic               clk,
   input  logic               rst,
   rom_burst_reader_if.slave  bus
);

   localparam int OCC_W = RBR_CNT_W + 1;

   rbr_state_e                 state_q, state_d;
   logic [READ_ADDR_WIDTH-1:0] base_q, base_d;
   logic [READ_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]       len_q, len_d;
   logic [LEN_WIDTH-1:0]       issue_cnt_q, issue_cnt_d;
   logic                       inflight_q;
   logic                       inflight_last_q;

   logic [WIDTH:0]             fifo_head;
   logic [RBR_CNT_W-1:0]       fifo_cnt;
   logic                       fifo_valid;
   logic                       pop;
   logic                       flush;
   logic                       rd_en;
   logic                       issue_last;
   logic                       abort_now;
   logic [OCC_W-1:0]           occupancy;

`ifdef ROM_BURST_READER_ABORT_EN
   assign abort_now = bus.i_abort && ((state_q == ST_FETCH) || (state_q == ST_DRAIN));
`else
   assign abort_now = 1'b0;
`endif

   // The head beat is withheld during an abort so a truncated burst never shows o_last.
   assign bus.o_valid = fifo_valid && !abort_now;
   assign bus.o_last  = fifo_valid && fifo_head[WIDTH] && !abort_now;
   assign bus.o_data  = fifo_head[WIDTH-1:0];
   assign pop         = bus.o_valid && bus.i_ready;
   assign flush       = abort_now;

   // Words that will sit in the FIFO after this edge, counting the one in flight.
   assign occupancy  = OCC_W'(fifo_cnt) + OCC_W'(inflight_q) - OCC_W'(pop);
   assign issue_last = (issue_cnt_q == len_q - LEN_WIDTH'(1));
   assign rd_en      = (state_q == ST_FETCH) && (issue_cnt_q != len_q) &&
                       (occupancy < OCC_W'(RBR_FIFO_DEPTH)) && !abort_now;
   assign addr_d     = rd_en ? base_q + READ_ADDR_WIDTH'(issue_cnt_q) : addr_q;

   assign bus.o_rom_rd_en = rd_en;
   assign bus.o_rom_addr  = addr_d;
   assign bus.o_busy      = (state_q != ST_IDLE);
   assign bus.o_done      = (state_q == ST_DONE);

   // NOTE: every next-state variable takes its hold value first, so no path
   // through the case statement leaves one unassigned and infers a latch.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      len_d       = len_q;
      issue_cnt_d = issue_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.i_start) begin
               base_d      = bus.i_base_addr;
               len_d       = bus.i_len;
               issue_cnt_d = '0;
               state_d     = (bus.i_len == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (abort_now) begin
               state_d = ST_DONE;
            end else if (rd_en) begin
               issue_cnt_d = issue_cnt_q + LEN_WIDTH'(1);
               if (issue_last) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (abort_now || (occupancy == '0)) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         base_q          <= '0;
         len_q           <= '0;
         issue_cnt_q     <= '0;
         addr_q          <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         base_q          <= base_d;
         len_q           <= len_d;
         issue_cnt_q     <= issue_cnt_d;
         addr_q          <= addr_d;
         inflight_q      <= rd_en;
         inflight_last_q <= rd_en && issue_last;
      end
   end

   rbr_skid_fifo #(
      .DATA_W (WIDTH + 1)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (inflight_q),
      .push_data_i ({inflight_last_q, bus.i_rom_data}),
      .pop_i       (pop),
      .flush_i     (flush),
      .head_o      (fifo_head),
      .valid_o     (fifo_valid),
      .count_o     (fifo_cnt)
   );

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader; the ROM model returns its own address as data.
// Define ROM_BURST_READER_ABORT_EN to also exercise the abort path.
module tb_rom_burst_reader;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int LW = 9;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rom_burst_reader_if #(.READ_ADDR_WIDTH(AW), .WIDTH(DW), .LEN_WIDTH(LW)) bus ();

   rom_burst_reader #(.READ_ADDR_WIDTH(AW), .WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ROM: registered output, 1-cycle latency, holds when not read.
   always @(posedge clk) if (bus.o_rom_rd_en) bus.i_rom_data <= bus.o_rom_addr;

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;
   int start_cyc;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor, sampled on the falling edge.
   logic [DW-1:0] beat_data [$];
   logic          beat_last [$];
   int            beat_cyc  [$];
   logic [AW-1:0] rd_addr   [$];
   int done_cnt, done_cyc, done_busy, busy_cycles, valid_seen, last_seen;
   int stall_err, occ_err, issued, popped;
   logic          prev_stall;
   logic [DW-1:0] prev_data;
   logic          prev_last;

   always @(negedge clk) begin
      if (!rst) begin
         if (prev_stall && (!bus.o_valid || bus.o_data !== prev_data || bus.o_last !== prev_last))
            stall_err++;
         prev_stall = bus.o_valid && !bus.i_ready;
         prev_data  = bus.o_data;
         prev_last  = bus.o_last;
         if (bus.o_valid) valid_seen++;
         if (bus.o_valid && bus.o_last) last_seen++;
         if (bus.o_busy) busy_cycles++;
         if (bus.o_rom_rd_en) begin
            rd_addr.push_back(bus.o_rom_addr);
            if (issued - popped + 1 - int'(bus.o_valid && bus.i_ready) > 2) occ_err++;
            issued++;
         end
         if (bus.o_valid && bus.i_ready) begin
            beat_data.push_back(bus.o_data);
            beat_last.push_back(bus.o_last);
            beat_cyc.push_back(cyc);
            popped++;
         end
         if (bus.o_done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = int'(bus.o_busy);
         end
      end
   end

   bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   task automatic clear_mon();
      beat_data.delete(); beat_last.delete(); beat_cyc.delete(); rd_addr.delete();
      done_cnt = 0; done_cyc = -1; done_busy = 0; busy_cycles = 0; valid_seen = 0;
      last_seen = 0; stall_err = 0; occ_err = 0; issued = 0; popped = 0;
      prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
   endtask

   task automatic start_burst(input logic [AW-1:0] base, input logic [LW-1:0] len);
      @(posedge clk); #1;
      bus.i_start = 1'b1; bus.i_base_addr = base; bus.i_len = len;
      @(posedge clk); #1;
      start_cyc   = cyc;
      bus.i_start = 1'b0;
   endtask

   task automatic run_until_done(input int budget, input bit toggle, input string name);
      bit hit = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (toggle) bus.i_ready = pat[i % 4];
         @(posedge clk); #1;
         if (done_cnt > 0) begin hit = 1'b1; break; end
      end
      bus.i_ready = 1'b1;
      total_cnt++;
      if (!hit) $display("FAIL %s_timeout: no o_done within %0d cycles", name, budget);
      else pass_cnt++;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_beats(input string name, input logic [AW-1:0] base, input int n);
      total_cnt++;
      if (beat_data.size() != n) $display("FAIL %s_count: got %0d beats, expected %0d", name, beat_data.size(), n);
      else pass_cnt++;
      for (int i = 0; i < n && i < beat_data.size(); i++) begin
         logic [DW-1:0] exp_d = DW'(base + AW'(i));
         total_cnt++;
         if (beat_data[i] !== exp_d || beat_last[i] !== (i == n - 1))
            $display("FAIL %s_beat%0d: got data %0h last %0b, expected data %0h last %0b",
                     name, i, beat_data[i], beat_last[i], exp_d, (i == n - 1));
         else pass_cnt++;
      end
      total_cnt++;
      if (done_cnt != 1) $display("FAIL %s_done_count: got %0d, expected 1", name, done_cnt);
      else pass_cnt++;
   endtask

   task automatic check_outputs_zero(input string name);
      total_cnt++;
      if ({bus.o_busy, bus.o_done, bus.o_rom_addr, bus.o_rom_rd_en, bus.o_data, bus.o_valid, bus.o_last} !== '0)
         $display("FAIL %s: got busy %0b done %0b addr %0h rd_en %0b data %0h valid %0b last %0b, expected all 0",
                  name, bus.o_busy, bus.o_done, bus.o_rom_addr, bus.o_rom_rd_en, bus.o_data, bus.o_valid, bus.o_last);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_outputs_zero("reset_outputs");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_outputs_zero("idle_after_reset");
   endtask

   task automatic test_basic();
      clear_mon();
      start_burst(8'h10, 9'd4);
      run_until_done(30, 1'b0, "basic");
      check_beats("basic", 8'h10, 4);
      total_cnt++;
      if (rd_addr.size() != 4) $display("FAIL basic_rd_en_count: got %0d, expected 4", rd_addr.size());
      else pass_cnt++;
      if (beat_cyc.size() == 4) begin
         total_cnt++;
         if (beat_cyc[0] != start_cyc + 2) $display("FAIL basic_first_valid: got cycle %0d, expected %0d", beat_cyc[0], start_cyc + 2);
         else pass_cnt++;
         total_cnt++;
         if (beat_cyc[3] != beat_cyc[0] + 3) $display("FAIL basic_throughput: got last beat cycle %0d, expected %0d", beat_cyc[3], beat_cyc[0] + 3);
         else pass_cnt++;
         total_cnt++;
         if (done_cyc != beat_cyc[3] + 1) $display("FAIL basic_done_timing: got cycle %0d, expected %0d", done_cyc, beat_cyc[3] + 1);
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      clear_mon();
      start_burst(8'h20, 9'd6);
      run_until_done(60, 1'b1, "bp");
      check_beats("bp", 8'h20, 6);
      total_cnt++;
      if (stall_err != 0) $display("FAIL bp_stall_stable: got %0d unstable stall cycles, expected 0", stall_err);
      else pass_cnt++;
      total_cnt++;
      if (occ_err != 0) $display("FAIL bp_occupancy: got %0d over-issue cycles, expected 0", occ_err);
      else pass_cnt++;
      total_cnt++;
      if (rd_addr.size() != 6) $display("FAIL bp_rd_en_count: got %0d, expected 6", rd_addr.size());
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      logic [AW-1:0] exp_a [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      clear_mon();
      start_burst(8'hFE, 9'd4);
      run_until_done(30, 1'b0, "wrap");
      check_beats("wrap", 8'hFE, 4);
      total_cnt++;
      if (rd_addr.size() != 4) $display("FAIL wrap_rd_count: got %0d, expected 4", rd_addr.size());
      else pass_cnt++;
      for (int i = 0; i < 4 && i < rd_addr.size(); i++) begin
         total_cnt++;
         if (rd_addr[i] !== exp_a[i]) $display("FAIL wrap_addr%0d: got %0h, expected %0h", i, rd_addr[i], exp_a[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_zero_len();
      clear_mon();
      start_burst(8'h33, 9'd0);
      run_until_done(10, 1'b0, "zero");
      total_cnt++;
      if (done_cnt != 1 || done_cyc != start_cyc)
         $display("FAIL zero_done: got %0d pulses at cycle %0d, expected 1 at cycle %0d", done_cnt, done_cyc, start_cyc);
      else pass_cnt++;
      total_cnt++;
      if (valid_seen != 0 || rd_addr.size() != 0)
         $display("FAIL zero_no_activity: got %0d valid and %0d rd_en cycles, expected 0 and 0", valid_seen, rd_addr.size());
      else pass_cnt++;
      total_cnt++;
      if (busy_cycles != 1 || done_busy != 1)
         $display("FAIL zero_busy: got %0d busy cycles (busy at done %0d), expected 1 (1)", busy_cycles, done_busy);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      bit hit = 1'b0;
      clear_mon();
      start_burst(8'h40, 9'd8);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (beat_data.size() >= 2) begin hit = 1'b1; break; end
      end
      total_cnt++;
      if (!hit) $display("FAIL rstmid_wait: got %0d beats in 20 cycles, expected 2", beat_data.size());
      else pass_cnt++;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_outputs_zero("rstmid_outputs");
      total_cnt++;
      if (done_cnt != 0) $display("FAIL rstmid_no_done: got %0d pulses, expected 0", done_cnt);
      else pass_cnt++;
      @(posedge clk); #1;
      rst = 1'b0;
      clear_mon();
      start_burst(8'h00, 9'd2);
      run_until_done(30, 1'b0, "rstmid_next");
      check_beats("rstmid_next", 8'h00, 2);
   endtask

   task automatic test_back_to_back();
      clear_mon();
      start_burst(8'h50, 9'd5);
      @(posedge clk); #1;
      bus.i_start = 1'b1; bus.i_base_addr = 8'h80; bus.i_len = 9'd3;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      run_until_done(30, 1'b0, "ignore_start");
      check_beats("ignore_start", 8'h50, 5);
      total_cnt++;
      if (rd_addr.size() != 5) $display("FAIL ignore_start_rd_count: got %0d, expected 5", rd_addr.size());
      else pass_cnt++;
   endtask

`ifdef ROM_BURST_READER_ABORT_EN
   task automatic test_abort();
      int snap;
      bit hit = 1'b0;
      clear_mon();
      start_burst(8'h60, 9'd8);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (beat_data.size() >= 2) begin hit = 1'b1; break; end
      end
      total_cnt++;
      if (!hit) $display("FAIL abort_wait: got %0d beats in 20 cycles, expected 2", beat_data.size());
      else pass_cnt++;
      @(posedge clk); #1;
      bus.i_abort = 1'b1;
      snap = valid_seen;
      @(posedge clk); #1;
      bus.i_abort = 1'b0;
      run_until_done(20, 1'b0, "abort");
      total_cnt++;
      if (valid_seen != snap || beat_data.size() != 2)
         $display("FAIL abort_no_valid: got %0d valid cycles and %0d beats, expected %0d and 2", valid_seen, beat_data.size(), snap);
      else pass_cnt++;
      total_cnt++;
      if (done_cnt != 1 || last_seen != 0)
         $display("FAIL abort_done: got %0d done and %0d last, expected 1 and 0", done_cnt, last_seen);
      else pass_cnt++;
   endtask
`endif

   initial begin
      bus.i_start = 1'b0; bus.i_base_addr = '0; bus.i_len = '0;
      bus.i_ready = 1'b1; bus.i_rom_data = '0;
`ifdef ROM_BURST_READER_ABORT_EN
      bus.i_abort = 1'b0;
`endif
      clear_mon();
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero_len();
      test_reset_mid();
      test_back_to_back();
`ifdef ROM_BURST_READER_ABORT_EN
      test_abort();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
